// File: rtl/uc_pkg.sv
// Shared types and constants for the control unit and its decoder.
package uc_pkg;

   localparam int unsigned OPC_W    = 6;
   localparam int unsigned ALU_OP_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_STEP  = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   // Opcode classes: ALU is 0xxxxx, the others match on inst[15:12]
   localparam logic             OPC_ALU_MSB = 1'b0;
   localparam logic [3:0]       OPC_LI      = 4'b1000;
   localparam logic [3:0]       OPC_J       = 4'b1001;
   localparam logic [3:0]       OPC_JZ      = 4'b1010;
   localparam logic [3:0]       OPC_JNZ     = 4'b1011;
   localparam logic [OPC_W-1:0] OPC_HALT    = 6'b111111;

   typedef logic [ALU_OP_W-1:0] alu_op_t;
   localparam alu_op_t ALU_OP_NONE = 3'b000;

   // Datapath control strobes
   typedef struct packed {
      logic    s_inc;
      logic    s_inm;
      logic    we3;
      logic    wez;
      alu_op_t op_alu;
      logic    pc_en;
   } ctrl_t;

   // Strobes driven whenever the unit is not executing
   localparam ctrl_t CTRL_IDLE = '{
      s_inc  : 1'b1,
      s_inm  : 1'b0,
      we3    : 1'b0,
      wez    : 1'b0,
      op_alu : ALU_OP_NONE,
      pc_en  : 1'b0
   };

endpackage

// File: rtl/uc_secuenciador_if.sv
// Datapath <-> control unit signal bundle plus run/step/debug lines.
interface uc_secuenciador_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic [5:0]       opcode;
   logic             z;
   logic             run;
   logic             step;
   logic             s_inc;
   logic             s_inm;
   logic             we3;
   logic             wez;
   logic [2:0]       op_alu;
   logic             pc_en;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   // Datapath / debug host side
   modport master (
      output opcode, z, run, step,
      input  s_inc, s_inm, we3, wez, op_alu, pc_en, halted, illegal, retired
   );

   // Control unit side
   modport slave (
      input  opcode, z, run, step,
      output s_inc, s_inm, we3, wez, op_alu, pc_en, halted, illegal, retired
   );
endinterface

// File: rtl/uc_decode.sv
// Combinational opcode/z decoder producing raw (ungated) strobes.
module uc_decode
   import uc_pkg::*;
#(
   parameter bit RESERVED_IS_NOP = 1'b1
) (
   input  logic [OPC_W-1:0] i_opcode,
   input  logic             i_z,
   output ctrl_t            o_ctrl,
   output logic             o_stop,
   output logic             o_trap
);

   // Opcode class decode; o_stop marks HALT or a trapped reserved opcode
   always_comb begin
      o_ctrl       = CTRL_IDLE;
      o_ctrl.pc_en = 1'b1;
      o_stop       = 1'b0;
      o_trap       = 1'b0;
      if (i_opcode[5] == OPC_ALU_MSB) begin
         o_ctrl.op_alu = i_opcode[4:2];
         o_ctrl.we3    = 1'b1;
         o_ctrl.wez    = 1'b1;
      end else begin
         case (i_opcode[5:2])
            OPC_LI: begin
               o_ctrl.we3   = 1'b1;
               o_ctrl.s_inm = 1'b1;
            end
            OPC_J:   o_ctrl.s_inc = 1'b0;
            OPC_JZ:  o_ctrl.s_inc = ~i_z;
            OPC_JNZ: o_ctrl.s_inc = i_z;
            default: begin
               if (i_opcode == OPC_HALT) begin
                  o_ctrl.pc_en = 1'b0;
                  o_stop       = 1'b1;
               end else if (!RESERVED_IS_NOP) begin
                  o_ctrl.pc_en = 1'b0;
                  o_stop       = 1'b1;
                  o_trap       = 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/uc_secuenciador.sv
// Control unit: run/pause/step/halt sequencer, decode gating, retired counter.
module uc_secuenciador
   import uc_pkg::*;
#(
   parameter int unsigned CNT_W           = 16,
   parameter bit          RESERVED_IS_NOP = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   uc_secuenciador_if.slave bus
);

   state_e           r_state;
   state_e           w_next;
   logic             r_step_q;
   logic             r_halted;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;
   logic             w_step_rise;
   logic             w_exec;
   logic             w_stop;
   logic             w_trap;
   ctrl_t            w_dec;
   ctrl_t            w_ctrl;

   assign w_step_rise = bus.step & ~r_step_q;
   assign w_exec      = (r_state == ST_RUN) || (r_state == ST_STEP);

   uc_decode #(
      .RESERVED_IS_NOP (RESERVED_IS_NOP)
   ) u_decode (
      .i_opcode (bus.opcode),
      .i_z      (bus.z),
      .o_ctrl   (w_dec),
      .o_stop   (w_stop),
      .o_trap   (w_trap)
   );

   // Strobes pass through only on execute cycles
   always_comb begin
      w_ctrl = CTRL_IDLE;
      if (w_exec) begin
         w_ctrl = w_dec;
      end
   end

   // Next-state logic; run wins over a simultaneous step edge
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_PAUSE: begin
            if (bus.run) begin
               w_next = ST_RUN;
            end else if (w_step_rise) begin
               w_next = ST_STEP;
            end
         end
         ST_RUN: begin
            if (w_stop) begin
               w_next = ST_HALT;
            end else if (!bus.run) begin
               w_next = ST_PAUSE;
            end
         end
         ST_STEP: w_next = w_stop ? ST_HALT : ST_PAUSE;
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Step edge history and halt/illegal status flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_step_q  <= 1'b0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_step_q <= bus.step;
         r_halted <= (w_next == ST_HALT);
         if (w_exec && w_trap) begin
            r_illegal <= 1'b1;
         end
      end
   end

   // Saturating retired-instruction counter; HALT/trap cycles do not retire
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired <= '0;
      end else if (w_exec && !w_stop && (r_retired != {CNT_W{1'b1}})) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign bus.s_inc   = w_ctrl.s_inc;
   assign bus.s_inm   = w_ctrl.s_inm;
   assign bus.we3     = w_ctrl.we3;
   assign bus.wez     = w_ctrl.wez;
   assign bus.op_alu  = w_ctrl.op_alu;
   assign bus.pc_en   = w_ctrl.pc_en;
   assign bus.halted  = r_halted;
   assign bus.illegal = r_illegal;
   assign bus.retired = r_retired;

endmodule

// File: doc/uc_secuenciador.md
Name: uc_secuenciador

Overview:
- Control unit for the 16-bit single-cycle datapath.
- Consumes the 6-bit opcode and the registered zero flag from the datapath.
- Drives the datapath control strobes (s_inc, s_inm, we3, wez, op_alu) plus a PC enable (pc_en) that gates the PC register.
- Adds run/pause/single-step/halt sequencing and a retired-instruction counter for debug and bring-up.

Parameters:
- CNT_W, 16: width of retired-instruction counter.
- RESERVED_IS_NOP, 1: 1 = opcodes 11xxxx other than HALT execute as NOP; 0 = they trap (illegal=1, enter HALT).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  inst[15:10] from datapath
- z  in  1  registered zero flag from datapath
- run  in  1  level: 1 = free-run, 0 = pause
- step  in  1  single-step request; rising edge detected internally
- s_inc  out  1  PC mux select: 1 = PC+1, 0 = inst[9:0]
- s_inm  out  1  write-data mux select: 1 = immediate inst[11:4], 0 = ALU result
- we3  out  1  register-file write enable
- wez  out  1  zero-flag register load enable
- op_alu  out  3  ALU operation
- pc_en  out  1  PC register load enable
- halted  out  1  registered; 1 in HALT state
- illegal  out  1  registered, sticky; reserved opcode trapped
- retired  out  CNT_W  executed-instruction count, saturating

Behaviour:
- States: IDLE, RUN, PAUSE, STEP, HALT.
- Reset: asserted low, applies immediately without a clock edge.
  - State = IDLE; retired = 0; halted = 0; illegal = 0; step_q = 0.
  - Effect on outputs is immediate.
- Execute cycle: exec = (state==RUN) | (state==STEP).
- Outputs when exec=0: we3=0, wez=0, pc_en=0, s_inc=1, s_inm=0, op_alu=000.
- Decode when exec=1; all outputs combinational from state, opcode and z, with zero latency:
  - 0xxxxx, ALU: op_alu=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1, pc_en=1.
  - 1000xx, LI: we3=1, s_inm=1, wez=0, s_inc=1, pc_en=1.
  - 1001xx, J: s_inc=0, pc_en=1, no writes.
  - 1010xx, JZ: s_inc=~z, pc_en=1.
  - 1011xx, JNZ: s_inc=z, pc_en=1.
  - 111111, HALT: no writes, pc_en=0, so PC stays on the HALT instruction.
  - Other 11xxxx: if RESERVED_IS_NOP=1, s_inc=1, pc_en=1, no writes. If RESERVED_IS_NOP=0, same as HALT and illegal is set.
  - op_alu=000 for every non-ALU opcode.
- Step edge detect: step_rise = step & ~step_q; step_q registered every cycle in all states.
- Transitions (evaluated at the rising edge):
  - IDLE: run=1 -> RUN; else step_rise -> STEP; else stay.
  - RUN: executing HALT/trap -> HALT; else run=0 -> PAUSE; else stay. The instruction present in the cycle run first reads 0 still executes.
  - STEP: HALT/trap -> HALT; else -> PAUSE. Exactly one exec cycle per step edge.
  - PAUSE: run=1 -> RUN (run has priority over a simultaneous step_rise); else step_rise -> STEP.
  - HALT: sticky; leaves only via reset. run and step are ignored.
- step_rise in RUN, STEP or HALT is discarded; it is not queued.
- retired: +1 on every exec cycle except HALT/trap; saturates at 2^CNT_W-1 with no wrap.
- halted and illegal are registered and assert the cycle after the HALT/trap exec cycle.

Decomposition:
- Package uc_pkg holds:
  - State enum.
  - Opcode class constants: OPC_ALU_MSB, OPC_LI=4'b1000, OPC_J=4'b1001, OPC_JZ=4'b1010, OPC_JNZ=4'b1011, OPC_HALT=6'b111111.
  - ALU op codes.
- Sub-module uc_decode: purely combinational opcode/z -> raw strobes. The top gates the strobes with exec and holds the FSM, edge detector and counter.

Test Plan:
- Reset: reset=0 mid-RUN with no clock edge -> we3=0, pc_en=0, halted=0, retired=0 immediately; after release with run=0, state stays IDLE.
- ALU and LI: run=1, opcode=000100 -> op_alu=001, we3=1, wez=1, s_inc=1, pc_en=1, retired +1 per cycle. opcode=100000 -> s_inm=1, wez=0.
- Branches: opcode=101000 with z=1 -> s_inc=0; with z=0 -> s_inc=1. opcode=101100 with z=1 -> s_inc=1. opcode=100100 -> s_inc=0.
- Single step: PAUSE, step held high 5 cycles -> exactly one cycle with pc_en=1, retired +1, return to PAUSE. run=1 and step rising in the same cycle -> RUN.
- HALT: run=1, opcode=111111 -> pc_en=0 and we3=0 that cycle; halted=1 next cycle; retired unchanged; later run/step toggles produce no exec.
- Trap: RESERVED_IS_NOP=0, opcode=110000 -> no writes; illegal=1 and halted=1 next cycle. With RESERVED_IS_NOP=1, same opcode -> pc_en=1, s_inc=1, retired +1. Preload retired near max -> saturates at 0xFFFF.
